// File: rtl/red_pitaya_pid_sp_ramp_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// red_pitaya_pid_sp_ramp_if
//   Control/status bundle between the PID register file and the ramp block.
//   Revision: 1.0
// ---------------------------------------------------------------------------
interface red_pitaya_pid_sp_ramp_if #(
    parameter int DW = 14,
    parameter int CW = 16
);
    logic          start_i;
    logic          abort_i;
    logic [DW-1:0] target_i;
    logic [DW-1:0] step_i;
    logic [CW-1:0] div_i;
    logic [DW-1:0] sp_o;
    logic          busy_o;
    logic          done_o;

    modport master (
        output start_i, abort_i, target_i, step_i, div_i,
        input  sp_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, target_i, step_i, div_i,
        output sp_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/red_pitaya_pid_sp_ramp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// red_pitaya_pid_sp_ramp
//   Moves a PID set point toward a target in saturating, paced steps.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module red_pitaya_pid_sp_ramp #(
    parameter int DW = 14,
    parameter int CW = 16
) (
    input  wire logic               clk_i,
    input  wire logic               rstn_i,
    red_pitaya_pid_sp_ramp_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] sp;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
    logic [DW-1:0] target_l;
    logic [DW-1:0] step_l;
    logic [CW-1:0] div_l;

    logic signed [DW:0] diff;
    logic        [DW:0] mag;
    logic               last_step;
    logic [DW-1:0]      sp_next;

    // One extra bit keeps target - sp exact across the full signed range.
    assign diff      = $signed({target_l[DW-1], target_l}) - $signed({sp[DW-1], sp});
    assign mag       = diff[DW] ? -diff : diff;
    assign last_step = (step_l == '0) || (mag <= {1'b0, step_l});
    assign sp_next   = diff[DW] ? (sp - step_l) : (sp + step_l);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            sp       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            target_l <= '0;
            step_l   <= '0;
            div_l    <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start_i && !bus.abort_i) begin
                    target_l <= bus.target_i;
                    step_l   <= bus.step_i;
                    div_l    <= bus.div_i;
                    cnt      <= '0;
                    state    <= RAMP;
                    busy     <= 1'b1;
                end
            end else begin
                if (bus.abort_i) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (bus.start_i) begin
                    target_l <= bus.target_i;
                    step_l   <= bus.step_i;
                    div_l    <= bus.div_i;
                    cnt      <= '0;
                end else if (cnt == div_l) begin
                    cnt <= '0;
                    if (last_step) begin
                        sp    <= target_l;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        sp <= sp_next;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.sp_o   = sp;
    assign bus.busy_o = busy;
    assign bus.done_o = done;

endmodule
`default_nettype wire
